// File: rtl/mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pipe
// Purpose  : Pipeline memory stage between execute and write-back. Accepts one
//            operation per valid/ready handshake, performs loads/stores against
//            an internal word-addressed memory with MEM_LAT cycles of access
//            latency, and presents the write-back word through a registered
//            valid/ready output with stall (out_ready) and freeze (halt_sys).
// Ports    : clk, rst (sync, active-low)     - clock and reset
//            halt_sys                        - global freeze
//            in_valid/in_ready               - upstream handshake
//            alu, mem2r, memwr, r1_data, r0_en - operation operands
//            out_valid/out_ready             - downstream handshake
//            data, mem_data, out_mem2r, out_memwr, out_r0_en - result
//            addr_err (sticky), busy         - status
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_pipe #(
  parameter int DATA_W  = 16,
  parameter int HI_W    = 16,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt_sys,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [HI_W+DATA_W-1:0]   alu,
  input  logic                     mem2r,
  input  logic                     memwr,
  input  logic [DATA_W-1:0]        r1_data,
  input  logic                     r0_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [HI_W+DATA_W-1:0]   data,
  output logic [DATA_W-1:0]        mem_data,
  output logic                     out_mem2r,
  output logic                     out_memwr,
  output logic                     out_r0_en,
  output logic                     addr_err,
  output logic                     busy
);

  localparam int               c_W        = HI_W + DATA_W;
  localparam int               c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W:0]  c_DEPTH    = (DATA_W+1)'(DEPTH);
  localparam logic [2:0]       c_CNT_INIT = 3'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic             c_SINGLE   = (MEM_LAT == 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;

  // Operands captured at acceptance of a multi-cycle memory op
  logic [c_W-1:0]    r_alu;
  logic              r_mem2r, r_memwr, r_r0_en;
  logic [DATA_W-1:0] r_r1_data;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_out_valid, r_out_mem2r, r_out_memwr, r_out_r0_en, r_addr_err;
  logic [c_W-1:0]    r_data;
  logic [DATA_W-1:0] r_mem_data;

  logic              w_idle, w_in_ready, w_accept, w_in_mem_op, w_start, w_complete;
  logic [c_W-1:0]    w_op_alu;
  logic              w_op_mem2r, w_op_memwr, w_op_r0_en, w_op_mem;
  logic [DATA_W-1:0] w_op_r1, w_addr, w_load_val, w_mem_rd;
  logic              w_in_range;
  logic [c_AW-1:0]   w_idx;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_in_ready  = !halt_sys && w_idle && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_in_mem_op = mem2r || memwr;
  assign w_start     = w_accept && w_in_mem_op && !c_SINGLE;

  // In IDLE the completing op (if any) comes straight from the inputs; in
  // ACCESS it comes from the operands latched at acceptance.
  assign w_op_alu   = w_idle ? alu     : r_alu;
  assign w_op_mem2r = w_idle ? mem2r   : r_mem2r;
  assign w_op_memwr = w_idle ? memwr   : r_memwr;
  assign w_op_r0_en = w_idle ? r0_en   : r_r0_en;
  assign w_op_r1    = w_idle ? r1_data : r_r1_data;
  assign w_op_mem   = w_op_mem2r || w_op_memwr;

  assign w_addr     = w_op_alu[DATA_W-1:0];
  assign w_in_range = ({1'b0, w_addr} < c_DEPTH);
  assign w_idx      = w_addr[c_AW-1:0];

  assign w_complete = !halt_sys &&
                      ((w_idle && w_accept && (!w_in_mem_op || c_SINGLE)) ||
                       (!w_idle && (r_cnt == 3'd0)));

  // A combined store+load returns the word just written; out-of-range reads 0.
  assign w_load_val = w_in_range ? (w_op_memwr ? w_op_r1 : r_mem[w_idx]) : '0;
  assign w_mem_rd   = w_op_mem2r ? w_load_val : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!halt_sys) begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            w_state_nxt = ST_ACCESS;
            w_cnt_nxt   = c_CNT_INIT;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 3'd0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alu     <= '0;
      r_mem2r   <= 1'b0;
      r_memwr   <= 1'b0;
      r_r0_en   <= 1'b0;
      r_r1_data <= '0;
    end else if (w_start) begin
      r_alu     <= alu;
      r_mem2r   <= mem2r;
      r_memwr   <= memwr;
      r_r0_en   <= r0_en;
      r_r1_data <= r1_data;
    end
  end

  // Stores commit only at completion, so a reset mid-access drops them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem <= '{default: '0};
    end else if (w_complete && w_op_memwr && w_in_range) begin
      r_mem[w_idx] <= w_op_r1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_mem_data  <= '0;
      r_out_mem2r <= 1'b0;
      r_out_memwr <= 1'b0;
      r_out_r0_en <= 1'b0;
      r_addr_err  <= 1'b0;
    end else if (!halt_sys) begin
      if (w_complete) begin
        r_out_valid <= 1'b1;
        r_data      <= {w_op_alu[c_W-1:DATA_W],
                        (w_op_mem2r ? w_mem_rd : w_op_alu[DATA_W-1:0])};
        r_mem_data  <= w_mem_rd;
        r_out_mem2r <= w_op_mem2r;
        r_out_memwr <= w_op_memwr;
        r_out_r0_en <= w_op_r0_en;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_complete && w_op_mem && !w_in_range) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign data      = r_data;
  assign mem_data  = r_mem_data;
  assign out_mem2r = r_out_mem2r;
  assign out_memwr = r_out_memwr;
  assign out_r0_en = r_out_r0_en;
  assign addr_err  = r_addr_err;
  assign busy      = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_pipe
// Purpose  : Self-checking bench for mem_stage_pipe (DATA_W=16, HI_W=16,
//            DEPTH=256, MEM_LAT=2). A transaction-level model tracks the
//            memory contents, the op in flight and the result slot; a
//            negedge process compares every output against it each cycle.
//            Directed sequences pin the model with literal expectations,
//            followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_pipe;

  localparam int DATA_W  = 16;
  localparam int HI_W    = 16;
  localparam int DEPTH   = 256;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, halt_sys, in_valid, mem2r, memwr, r0_en, out_ready;
  logic [31:0] alu;
  logic [15:0] r1_data;
  logic        in_ready, out_valid, out_mem2r, out_memwr, out_r0_en, addr_err, busy;
  logic [31:0] data;
  logic [15:0] mem_data;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  mem_stage_pipe #(
    .DATA_W(DATA_W), .HI_W(HI_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu(alu), .mem2r(mem2r), .memwr(memwr), .r1_data(r1_data), .r0_en(r0_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .data(data), .mem_data(mem_data),
    .out_mem2r(out_mem2r), .out_memwr(out_memwr), .out_r0_en(out_r0_en),
    .addr_err(addr_err), .busy(busy)
  );

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_left;               // edges until the in-flight op finishes
  logic [31:0] p_alu;
  logic        p_mem2r, p_memwr, p_r0_en;
  logic [15:0] p_r1;
  bit          m_out_valid, m_mem2r, m_memwr, m_r0_en, m_err;
  logic [31:0] m_data;
  logic [15:0] m_mem_data;

  task automatic finish_op(input logic [31:0] a, input logic m2r, input logic mw,
                           input logic [15:0] d, input logic r0);
    int unsigned addr;
    bit inr;
    logic [15:0] rd;
    addr = a[15:0];
    inr  = addr < DEPTH;
    if ((m2r || mw) && !inr) m_err = 1'b1;
    if (mw && inr) m_mem[addr] = d;
    rd = (m2r && inr) ? m_mem[addr] : 16'h0;
    m_out_valid = 1'b1;
    m_mem_data  = rd;
    m_data      = {a[31:16], (m2r ? rd : a[15:0])};
    m_mem2r     = m2r;
    m_memwr     = mw;
    m_r0_en     = r0;
  endtask

  task automatic model_step();
    bit rdy, cons, done;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
      m_busy = 0; m_left = 0; m_out_valid = 0; m_err = 0;
      m_data = 0; m_mem_data = 0; m_mem2r = 0; m_memwr = 0; m_r0_en = 0;
    end else if (!halt_sys) begin
      rdy  = !m_busy && (!m_out_valid || out_ready);
      cons = m_out_valid && out_ready;
      done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          finish_op(p_alu, p_mem2r, p_memwr, p_r1, p_r0_en);
          m_busy = 0;
          done   = 1;
        end
      end else if (in_valid && rdy) begin
        if (!(mem2r || memwr) || MEM_LAT == 1) begin
          finish_op(alu, mem2r, memwr, r1_data, r0_en);
          done = 1;
        end else begin
          p_alu = alu; p_mem2r = mem2r; p_memwr = memwr; p_r1 = r1_data; p_r0_en = r0_en;
          m_left = MEM_LAT - 1;
          m_busy = 1;
        end
      end
      if (!done && cons) m_out_valid = 0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_out_valid));
      chk("data",      64'(data),      64'(m_data));
      chk("mem_data",  64'(mem_data),  64'(m_mem_data));
      chk("out_mem2r", 64'(out_mem2r), 64'(m_mem2r));
      chk("out_memwr", 64'(out_memwr), 64'(m_memwr));
      chk("out_r0_en", 64'(out_r0_en), 64'(m_r0_en));
      chk("addr_err",  64'(addr_err),  64'(m_err));
      chk("busy",      64'(busy),      64'(m_busy));
      chk("in_ready",  64'(in_ready),
          64'(!halt_sys && !m_busy && (!m_out_valid || out_ready)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic m2r, input logic mw,
                       input logic [15:0] d, input logic r0);
    in_valid = 1'b1; alu = a; mem2r = m2r; memwr = mw; r1_data = d; r0_en = r0;
  endtask

  task automatic idle();
    in_valid = 1'b0; mem2r = 1'b0; memwr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; halt_sys = 1'b0; in_valid = 1'b0; mem2r = 1'b0; memwr = 1'b0;
    alu = '0; r1_data = '0; r0_en = 1'b0; out_ready = 1'b1;

    // Reset
    cyc();
    cmp_en = 1'b1;
    cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data",      64'(data),      64'd0);
    chk("rst_addr_err",  64'(addr_err),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b1;

    // Load from a freshly reset word
    drive(32'h0000_0005, 1, 0, 16'h0, 0);
    cyc(); idle();
    chk("ld5_in_ready", 64'(in_ready), 64'd0);
    cyc();
    chk("ld5_valid",    64'(out_valid), 64'd1);
    chk("ld5_mem_data", 64'(mem_data),  64'h0);
    cyc();

    // Store then load
    drive(32'h1234_0010, 0, 1, 16'hBEEF, 0);
    cyc(); idle();
    chk("st_in_ready", 64'(in_ready),  64'd0);
    chk("st_valid0",   64'(out_valid), 64'd0);
    cyc();
    chk("st_valid1",   64'(out_valid), 64'd1);
    chk("st_memwr",    64'(out_memwr), 64'd1);
    chk("st_data",     64'(data),      64'h1234_0010);
    drive(32'hABCD_0010, 1, 0, 16'h0, 1);
    #1 chk("ld_in_ready", 64'(in_ready), 64'd1);
    cyc(); idle();
    cyc();
    chk("ld_data",     64'(data),     64'hABCD_BEEF);
    chk("ld_mem_data", 64'(mem_data), 64'hBEEF);
    chk("ld_r0_en",    64'(out_r0_en), 64'd1);
    chk("model_ld",    64'(m_data),   64'hABCD_BEEF);

    // Non-mem back-to-back
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i), 0, 0, 16'h0, 0);
      #1 chk("nm_in_ready", 64'(in_ready), 64'd1);
      cyc();
      chk("nm_valid", 64'(out_valid), 64'd1);
      chk("nm_data",  64'(data),      64'(i));
    end
    idle();
    cyc();
    chk("nm_drain", 64'(out_valid), 64'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(32'h0000_0010, 1, 0, 16'h0, 0);
    cyc(); idle();
    cyc();
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_data",  64'(data),      64'h0000_BEEF);
    repeat (2) cyc();
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_data",  64'(data),      64'h0000_BEEF);
    chk("bp_in_ready",   64'(in_ready),  64'd0);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    cyc();
    chk("bp_consumed", 64'(out_valid), 64'd0);

    // Address error: out-of-range store must not alias into word 0
    drive(32'h0000_0100, 0, 1, 16'h5555, 0);
    cyc(); idle();
    cyc();
    chk("ae_set", 64'(addr_err), 64'd1);
    drive(32'h0000_0000, 1, 0, 16'h0, 0);
    cyc(); idle();
    cyc();
    chk("ae_word0",  64'(mem_data), 64'h0);
    chk("ae_sticky", 64'(addr_err), 64'd1);
    drive(32'h0000_0100, 1, 0, 16'h0, 0);
    cyc(); idle();
    cyc();
    chk("ae_oor_load", 64'(mem_data), 64'h0);

    // Halt during ACCESS stretches completion by the halted cycles
    drive(32'h0000_0010, 1, 0, 16'h0, 0);
    cyc(); idle();
    halt_sys = 1'b1;
    repeat (3) begin
      cyc();
      chk("halt_no_done", 64'(out_valid), 64'd0);
      chk("halt_busy",    64'(busy),      64'd1);
    end
    halt_sys = 1'b0;
    cyc();
    chk("halt_done",     64'(out_valid), 64'd1);
    chk("halt_mem_data", 64'(mem_data),  64'hBEEF);
    halt_sys = 1'b1;
    cyc();
    chk("halt_keep_valid", 64'(out_valid), 64'd1);
    chk("halt_in_ready",   64'(in_ready),  64'd0);
    halt_sys = 1'b0;
    cyc();
    chk("halt_consumed", 64'(out_valid), 64'd0);

    // Reset mid-ACCESS of a store leaves the word at 0
    drive(32'h0000_0020, 0, 1, 16'h7777, 0);
    cyc(); idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("rma_busy", 64'(busy), 64'd0);
    drive(32'h0000_0020, 1, 0, 16'h0, 0);
    cyc(); idle();
    cyc();
    chk("rma_word", 64'(mem_data), 64'h0);

    // Randomized traffic
    repeat (3000) begin
      rst       = ($urandom_range(0, 199) != 0);
      halt_sys  = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      mem2r     = $urandom_range(0, 1);
      memwr     = $urandom_range(0, 1);
      r0_en     = $urandom_range(0, 1);
      r1_data   = 16'($urandom);
      alu[31:16] = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       alu[15:0] = 16'($urandom);
        1:       alu[15:0] = 16'($urandom_range(250, 260));
        default: alu[15:0] = 16'($urandom_range(0, 15));
      endcase
      cyc();
    end
    rst = 1'b1; halt_sys = 1'b0; idle();
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Parametrised pipeline memory stage, the successor to the fixed 16-bit single-cycle stage-three. It sits between the execute stage and write-back. It accepts one operation per handshake and performs loads and stores against an internal word-addressed data memory with configurable access latency. It forms the write-back word (ALU upper half plus either memory data or ALU lower half) and presents it through a registered valid/ready output with stall and halt support.

## Interface
Parameters:
- DATA_W, 16, width of the memory word, store data and the low half of the ALU result
- HI_W, 16, width of the ALU upper half passed straight through to `data`
- DEPTH, 256, number of memory words; legal address range 0..DEPTH-1
- MEM_LAT, 2, cycles from acceptance to completion for load/store ops; legal range 1..4

Ports:
- clk  in  1  stage clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- halt_sys  in  1  global freeze; while 1 no state, memory or output changes
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept this cycle
- alu  in  HI_W+DATA_W  ALU result; low DATA_W bits are the memory address for mem ops
- mem2r  in  1  load: write-back low half comes from memory
- memwr  in  1  store r1_data to mem[alu low]
- r1_data  in  DATA_W  store data
- r0_en  in  1  register-0 write enable, carried through
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream accepts result
- data  out  HI_W+DATA_W  {alu hi, mem2r ? mem_data : alu lo}, registered
- mem_data  out  DATA_W  load data (0 for non-loads), registered
- out_mem2r, out_memwr, out_r0_en  out  1 each  control bits carried with the result
- addr_err  out  1  sticky; set by any mem op with address >= DEPTH
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ACCESS.
- Memory op = mem2r | memwr. mem2r and memwr both 1 is treated as a store followed by a read of the same word: mem_data returns r1_data.
- IDLE, accept (in_valid & in_ready):
  - Non-mem op: the output registers load on the same edge and out_valid=1. The state stays IDLE.
  - Mem op with MEM_LAT=1: completes on the accepting edge, like a non-mem op.
  - Mem op with MEM_LAT>1: the operands are latched, cnt=MEM_LAT-2, and the state goes to ACCESS.
- ACCESS: cnt decrements each cycle. On the edge where cnt==0 the op completes:
  - a store writes the memory;
  - a load samples the memory word;
  - the output registers load, out_valid=1, and the state returns to IDLE.
- in_ready = !halt_sys & state==IDLE & (!out_valid | out_ready).
- Output registers update only on completion. When the last result is consumed with no new completion, out_valid clears (out_valid & out_ready → 0).
- Out-of-range address (alu low >= DEPTH):
  - a store is dropped;
  - a load returns 0;
  - addr_err is set, and only reset clears it.
- Non-mem ops: mem_data=0 and data = alu unchanged.
- halt_sys=1 freezes everything: FSM, cnt, the memory write and all outputs hold. in_ready=0. out_valid is not cleared even if out_ready=1.
- Reset (rst=0 at an edge) clears, regardless of halt_sys:
  - all memory words to 0;
  - FSM to IDLE, cnt to 0;
  - all outputs to 0, so in_ready reads 1 once rst=1 with no halt.
- A reset during ACCESS aborts the op; a pending store is not written.

## Timing
- Result latency from the accepting edge: non-mem 0 extra cycles (valid the cycle after acceptance). A mem op completes MEM_LAT-1 edges after the accepting edge.
- Throughput:
  - non-mem ops, and mem ops with MEM_LAT=1: one per cycle when out_ready=1;
  - other mem ops: one per MEM_LAT cycles.
- Read-after-write: a load accepted after a store has completed sees the new data. There is never more than one op in flight.
- Inputs are sampled only on the accepting edge; they may change freely during ACCESS.

## Test plan
- Reset with DEPTH=256, MEM_LAT=2, then hold rst=0 for one cycle:
  - all outputs are 0 and in_ready=1;
  - a load from addr 0x0005 returns mem_data=0x0000.
- Store then load:
  - store r1_data=0xBEEF at alu=0x1234_0010; in_ready=0 for one cycle, out_valid appears 2 cycles after acceptance with out_memwr=1;
  - load alu=0xABCD_0010 gives data=0xABCD_BEEF and mem_data=0xBEEF.
- Non-mem back-to-back with out_ready=1:
  - 4 ops with alu=1,2,3,4 give data 1,2,3,4 on 4 consecutive cycles;
  - in_ready stays 1 throughout.
- Backpressure:
  - with out_ready=0, a completed load holds data and out_valid, and in_ready=0;
  - raising out_ready consumes the result and in_ready returns to 1 the same cycle.
- Address error and halt:
  - a store to 0x0100 (DEPTH=256) sets addr_err; a subsequent load from 0x0000 is unchanged;
  - halt_sys=1 during ACCESS stretches completion by exactly the number of halted cycles;
  - a reset mid-ACCESS of a store leaves the target word 0.
